// File: rtl/bram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_burst_ctrl
// Description : BRAM port controller. Single-word reads/writes with byte
//               enables, plus an autonomous burst-read engine. Read data is
//               tagged valid after RD_LATENCY cycles and held between beats.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_burst_ctrl #(
    parameter int DAT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wren,
    input  logic [DAT_WIDTH/8-1:0]  req_be,
    input  logic [DAT_WIDTH-1:0]    req_idat,
    input  logic                    req_rden,
    output logic                    req_rdy,
    input  logic                    brst_start,
    input  logic [ADDR_WIDTH-1:0]   brst_addr,
    input  logic [LEN_WIDTH-1:0]    brst_len,
    output logic                    brst_busy,
    output logic                    brst_done,
    output logic [DAT_WIDTH-1:0]    odat,
    output logic                    oval,
    output logic                    olast,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DAT_WIDTH-1:0]    mem_idat,
    output logic [DAT_WIDTH/8-1:0]  mem_wren,
    output logic                    mem_enb,
    output logic                    mem_rst,
    input  logic [DAT_WIDTH-1:0]    mem_odat
);

    localparam int NUM_BYTE = DAT_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_baddr;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_idx;
    logic [RD_LATENCY-1:0]   r_vld_pipe;
    logic [RD_LATENCY-1:0]   r_last_pipe;
    logic [DAT_WIDTH-1:0]    r_hold;

    logic w_single_ok;
    logic w_wr;
    logic w_rd_single;
    logic w_burst_rd;
    logic w_rd_issue;
    logic w_last_issue;

    // A burst start always pre-empts a single access offered in the same cycle
    assign w_single_ok  = (r_state == ST_IDLE) && !brst_start;
    assign w_wr         = w_single_ok && req_wren;
    // Write wins when both single strobes are raised together
    assign w_rd_single  = w_single_ok && req_rden && !req_wren;
    assign w_burst_rd   = (r_state == ST_BURST);
    assign w_rd_issue   = w_rd_single || w_burst_rd;
    assign w_last_issue = w_burst_rd && (r_idx == (r_len - LEN_WIDTH'(1)));

    assign req_rdy   = w_single_ok;
    assign mem_addr  = w_burst_rd ? r_baddr : req_addr;
    assign mem_idat  = req_idat;
    assign mem_wren  = req_be & {NUM_BYTE{w_wr}};
    assign mem_enb   = w_wr || w_rd_issue;
    assign mem_rst   = 1'b0;

    assign brst_busy = (r_state != ST_IDLE);
    assign oval      = r_vld_pipe[RD_LATENCY-1];
    assign olast     = r_last_pipe[RD_LATENCY-1];
    assign brst_done = r_last_pipe[RD_LATENCY-1];
    assign odat      = oval ? mem_odat : r_hold;

    // Burst sequencer: latch job, walk addresses, drain until last beat returns
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_baddr <= '0;
            r_len   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (brst_start && (brst_len != '0)) begin
                        r_baddr <= brst_addr;
                        r_len   <= brst_len;
                        r_idx   <= '0;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    r_baddr <= r_baddr + ADDR_WIDTH'(ADDR_STEP);
                    r_idx   <= r_idx + LEN_WIDTH'(1);
                    if (w_last_issue) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_last_pipe[RD_LATENCY-1]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Valid/last tags travel alongside the BRAM read latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_rd_issue;
            r_last_pipe[0] <= w_last_issue;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld_pipe[k]  <= r_vld_pipe[k-1];
                r_last_pipe[k] <= r_last_pipe[k-1];
            end
        end
    end

    // Capture each valid beat so odat stays stable between beats
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (oval) begin
            r_hold <= mem_odat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_burst_ctrl
// Description : Bench for bram_burst_ctrl at read latencies 2, 1 and 4 driven
//               by shared stimulus, each with its own BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_burst_ctrl;

    localparam int NDUT = 3;
    localparam int MAXC = 1024;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    function automatic logic [31:0] preload(input int i);
        if (i >= 'h40 && i < 'h44) return 32'(i - 'h40 + 1);
        if (i == 'hFE) return 32'hA0A0_0001;
        if (i == 'hFF) return 32'hA0A0_0002;
        if (i == 'h00) return 32'hA0A0_0003;
        return 32'h0;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] req_addr, req_idat, brst_addr;
    logic        req_wren, req_rden, brst_start;
    logic [3:0]  req_be;
    logic [15:0] brst_len;

    logic [NDUT-1:0]       req_rdy_a, brst_busy_a, brst_done_a, oval_a, olast_a;
    logic [NDUT-1:0]       mem_enb_a, mem_rst_a;
    logic [NDUT-1:0][31:0] odat_a, mem_addr_a, mem_idat_a, mem_odat_a;
    logic [NDUT-1:0][3:0]  mem_wren_a;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic [31:0]      bmem [256];
        logic [3:0][31:0] rpipe;

        bram_burst_ctrl #(
            .DAT_WIDTH (32),
            .ADDR_WIDTH(32),
            .RD_LATENCY(L),
            .LEN_WIDTH (16),
            .ADDR_STEP (4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_addr  (req_addr),
            .req_wren  (req_wren),
            .req_be    (req_be),
            .req_idat  (req_idat),
            .req_rden  (req_rden),
            .req_rdy   (req_rdy_a[g]),
            .brst_start(brst_start),
            .brst_addr (brst_addr),
            .brst_len  (brst_len),
            .brst_busy (brst_busy_a[g]),
            .brst_done (brst_done_a[g]),
            .odat      (odat_a[g]),
            .oval      (oval_a[g]),
            .olast     (olast_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_idat  (mem_idat_a[g]),
            .mem_wren  (mem_wren_a[g]),
            .mem_enb   (mem_enb_a[g]),
            .mem_rst   (mem_rst_a[g]),
            .mem_odat  (mem_odat_a[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) bmem[i] <= preload(i);
        end

        // BRAM with L-cycle read latency, word index from byte address
        always @(posedge clk) begin
            if (mem_enb_a[g]) begin
                rpipe[0] <= bmem[mem_addr_a[g][9:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wren_a[g][b])
                        bmem[mem_addr_a[g][9:2]][b*8 +: 8] <= mem_idat_a[g][b*8 +: 8];
            end
            for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
        end
        assign mem_odat_a[g] = rpipe[L-1];
    end

    // ---------------- behavioural model state ----------------
    logic [31:0] ref_mem [256];
    bit          ev [NDUT][MAXC];
    bit          el [NDUT][MAXC];
    bit          eb [NDUT][MAXC];
    logic [31:0] ed [NDUT][MAXC];
    bit          eav [MAXC];
    logic [31:0] ea [MAXC];
    int          busy_end [NDUT];
    logic [31:0] hold [NDUT];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int d, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d cyc=%0d actual=%b required=%b", name, d, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT against the model
    always @(negedge clk) begin
        if (cmp_on && cyc < MAXC) begin
            for (int d = 0; d < NDUT; d++) begin
                chk1("oval", d, oval_a[d], ev[d][cyc]);
                chk1("olast", d, olast_a[d], el[d][cyc]);
                chk1("brst_done", d, brst_done_a[d], el[d][cyc]);
                chk1("brst_busy", d, brst_busy_a[d], eb[d][cyc]);
                chk1("mem_rst", d, mem_rst_a[d], 1'b0);
                chk("odat", d, odat_a[d], ev[d][cyc] ? ed[d][cyc] : hold[d]);
                if (ev[d][cyc]) hold[d] = ed[d][cyc];
                if (!rst) hold[d] = 32'h0;
            end
            if (eav[cyc]) begin
                chk("burst_addr", 0, mem_addr_a[0], ea[cyc]);
                chk1("burst_enb", 0, mem_enb_a[0], 1'b1);
                chk("burst_wren", 0, 32'(mem_wren_a[0]), 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_addr = '0; req_idat = '0; req_wren = 1'b0; req_rden = 1'b0; req_be = '0;
        brst_start = 1'b0; brst_addr = '0; brst_len = '0;
    endtask

    task automatic sched_read(input int d, input int c_issue, input logic [31:0] addr, input bit last);
        int t;
        t = c_issue + lat_of(d);
        ev[d][t] = 1'b1;
        ed[d][t] = ref_mem[addr[9:2]];
        el[d][t] = last;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be, input bit also_rd);
        req_addr = addr; req_idat = data; req_be = be; req_wren = 1'b1; req_rden = also_rd;
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[addr[9:2]][b*8 +: 8] = data[b*8 +: 8];
        #1;
        chk1("wr_rdy", 0, req_rdy_a[0], 1'b1);
        chk("wr_wren", 0, 32'(mem_wren_a[0]), 32'(be));
        step();
        clear_in();
    endtask

    task automatic do_read(input logic [31:0] addr);
        req_addr = addr; req_rden = 1'b1;
        for (int d = 0; d < NDUT; d++) sched_read(d, cyc, addr, 1'b0);
        #1;
        chk1("rd_enb", 0, mem_enb_a[0], 1'b1);
        step();
        clear_in();
    endtask

    task automatic start_burst(input logic [31:0] base, input logic [15:0] len, output int s);
        int n;
        n = int'(len);
        s = cyc;
        brst_start = 1'b1; brst_addr = base; brst_len = len;
        for (int d = 0; d < NDUT; d++) begin
            if (n != 0 && cyc > busy_end[d]) begin
                for (int i = 0; i < n; i++) sched_read(d, cyc + 1 + i, base + 32'(4 * i), i == n - 1);
                for (int c = cyc + 1; c <= cyc + n + lat_of(d); c++) eb[d][c] = 1'b1;
                busy_end[d] = cyc + n + lat_of(d);
                if (d == 0)
                    for (int i = 0; i < n; i++) begin
                        eav[cyc + 1 + i] = 1'b1;
                        ea[cyc + 1 + i]  = base + 32'(4 * i);
                    end
            end
        end
        #1;
        chk1("start_rdy", 0, req_rdy_a[0], 1'b0);
        chk("start_wren", 0, 32'(mem_wren_a[0]), 32'h0);
        step();
        clear_in();
    endtask

    task automatic reset_cycle();
        int r;
        r = cyc;
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            for (int c = r + 1; c < MAXC; c++) begin
                ev[d][c] = 1'b0; el[d][c] = 1'b0; eb[d][c] = 1'b0;
            end
            busy_end[d] = r;
        end
        for (int c = r + 1; c < MAXC; c++) eav[c] = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        int c;
        logic [31:0] exp_addr2 [4];
        logic [31:0] exp_addr4 [3];
        exp_addr2 = '{32'h100, 32'h104, 32'h108, 32'h10C};
        exp_addr4 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        clear_in();
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
        for (int d = 0; d < NDUT; d++) begin
            busy_end[d] = -1;
            hold[d] = 32'h0;
            for (int k = 0; k < MAXC; k++) ed[d][k] = 32'h0;
        end

        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        cmp_on = 1'b1;

        // Reset state
        chk1("rst_oval", 0, oval_a[0], 1'b0);
        chk1("rst_busy", 0, brst_busy_a[0], 1'b0);
        chk("rst_odat", 0, odat_a[0], 32'h0);
        chk1("rst_rdy", 0, req_rdy_a[0], 1'b1);

        // Byte-enabled write then read back, with hold after oval drops
        do_write(32'h10, 32'hDEAD_BEEF, 4'b0101, 1'b0);
        c = cyc;
        do_read(32'h10);
        step();
        chk1("t1_oval", 0, oval_a[0], 1'b1);
        chk("t1_odat", 0, odat_a[0], 32'h00AD_00EF);
        step();
        chk1("t1_oval_drop", 0, oval_a[0], 1'b0);
        chk("t1_odat_hold", 0, odat_a[0], 32'h00AD_00EF);

        // Write+read together: read dropped; then pipelined singles
        do_write(32'h20, 32'h1234_5678, 4'hF, 1'b1);
        do_read(32'h20);
        do_read(32'h100);
        do_read(32'h104);
        do_read(32'h108);
        repeat (6) step();

        // Burst base 0x100 len 4
        start_burst(32'h100, 16'd4, s);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", 0, mem_addr_a[0], exp_addr2[i]);
            chk1("t2_busy", 0, brst_busy_a[0], 1'b1);
            step();
        end
        chk("t2_beat3", 0, odat_a[0], 32'd3);
        step();
        chk("t2_beat4", 0, odat_a[0], 32'd4);
        chk1("t2_olast", 0, olast_a[0], 1'b1);
        chk1("t2_done", 0, brst_done_a[0], 1'b1);
        chk1("t2_busy_done", 0, brst_busy_a[0], 1'b1);
        step();
        chk1("t2_busy_end", 0, brst_busy_a[0], 1'b0);
        repeat (4) step();

        // Burst start and single write collide: burst wins
        req_addr = 32'h30; req_idat = 32'hFFFF_FFFF; req_be = 4'hF; req_wren = 1'b1;
        start_burst(32'h100, 16'd2, s);
        repeat (8) step();
        do_read(32'h30);
        repeat (6) step();

        // Address wrap
        start_burst(32'hFFFF_FFF8, 16'd3, s);
        for (int i = 0; i < 3; i++) begin
            chk("t4_addr", 0, mem_addr_a[0], exp_addr4[i]);
            step();
        end
        repeat (8) step();

        // Reset during beat 2 of a len-8 burst
        start_burst(32'h100, 16'd8, s);
        step();
        reset_cycle();
        chk1("t5_busy", 0, brst_busy_a[0], 1'b0);
        chk1("t5_oval", 0, oval_a[0], 1'b0);
        chk("t5_odat", 0, odat_a[0], 32'h0);
        chk1("t5_done", 0, brst_done_a[0], 1'b0);
        repeat (12) step();

        // Zero-length burst is ignored
        start_burst(32'h100, 16'd0, s);
        chk("t6_busy", 0, 32'(brst_busy_a), 32'h0);
        step();
        chk("t6_busy2", 0, 32'(brst_busy_a), 32'h0);

        // Latency 1 and 4 single-read timing
        c = cyc;
        do_read(32'h104);
        chk1("t6_l1_oval", 1, oval_a[1], 1'b1);
        chk("t6_l1_odat", 1, odat_a[1], 32'd2);
        chk1("t6_l4_early", 2, oval_a[2], 1'b0);
        step();
        step();
        chk1("t6_l4_early3", 2, oval_a[2], 1'b0);
        step();
        chk1("t6_l4_oval", 2, oval_a[2], 1'b1);
        chk("t6_l4_odat", 2, odat_a[2], 32'd2);
        repeat (6) step();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
